// File: rtl/adc_scan_sequencer.sv
// adc_scan_sequencer: LTC2308 scan sequencer for the ELF/VLF receiver.
// Fires one multi-channel scan per sample tick, drives CONVST/SCLK/SDI and
// tags each result with the channel it belongs to (the ADC converts the
// channel named by the previous frame's config word).
// Optional build macro ADC_TESTPAT_EN: adds test_mode, which replaces the
// sample word with {cur_ch, 9-bit frame counter}.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// IDLE      | pins quiet, waiting for enable with a non-zero channel mask
// PRIME     | set up the first-channel config; the frame that follows is
//           | discarded (primed = 0)
// WAIT_TICK | primed, waiting for the next sample tick
// CONVST    | CONVST pin high for CONVST_HI cycles
// CONV      | conversion wait, CONV_CYCLES cycles
// SHIFT     | 12 SCLK periods: result in on SDO, config out on SDI
// NEXT      | one cycle: hand the result to the output register
`timescale 1ns/1ps

module adc_scan_sequencer #(
    parameter int SCLK_HALF     = 2,
    parameter int CONVST_HI     = 2,
    parameter int CONV_CYCLES   = 80,
    parameter int SAMPLE_PERIOD = 500
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic [7:0]  ch_mask,
    input  logic        uni,
`ifdef ADC_TESTPAT_EN
    input  logic        test_mode,
`endif
    output logic        adc_convst,
    output logic        adc_sclk,
    output logic        adc_sdi,
    input  logic        adc_sdo,
    output logic [11:0] smp_data,
    output logic [2:0]  smp_ch,
    output logic        smp_first,
    output logic        smp_valid,
    input  logic        smp_ready,
    output logic [15:0] ovf_count,
    output logic [15:0] miss_count,
    output logic        busy
);

    typedef enum logic [2:0] {
        S_IDLE, S_PRIME, S_WAIT_TICK, S_CONVST, S_CONV, S_SHIFT, S_NEXT
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] div_q, tmr_q;
    logic        tick, tmr_done;
    logic [4:0]  half_q;
    logic        sclk_q;
    logic [11:0] sh_q;
    logic [7:0]  scan_mask_q;
    logic [2:0]  cur_ch_q, nxt_ch_q;
    logic        cur_first_q, nxt_first_q, last_q, mask_zero_q, primed_q;
    logic [3:0]  nb, lm, fs, bit_k;
    logic [5:0]  cfg_word;
    logic        at_next, load_smp;
`ifdef ADC_TESTPAT_EN
    logic [8:0]  frm_q;
`endif

    // Lowest set bit of m as {found, index}.
    function automatic logic [3:0] lowest_set(input logic [7:0] m);
        logic [3:0] r;
        r = 4'd0;
        for (int i = 7; i >= 0; i--) begin
            if (m[i]) r = {1'b1, 3'(i)};
        end
        return r;
    endfunction

    // Mask of channels strictly above c.
    function automatic logic [7:0] above(input logic [2:0] c);
        logic [7:0] m;
        m = 8'hFF;
        return m << ({1'b0, c} + 4'd1);
    endfunction

    assign tick     = enable && (div_q == 16'(SAMPLE_PERIOD - 1));
    assign tmr_done = (tmr_q == 16'd0);
    assign nb       = lowest_set(scan_mask_q & above(cur_ch_q));
    assign lm       = lowest_set(ch_mask);
    assign fs       = lowest_set(scan_mask_q);
    assign cfg_word = {1'b1, nxt_ch_q[0], nxt_ch_q[2], nxt_ch_q[1], uni, 1'b0};
    assign bit_k    = half_q[4:1];
    assign at_next  = (state_q == S_NEXT) && primed_q;
    assign load_smp = at_next && (!smp_valid || smp_ready);
    assign adc_sclk = sclk_q;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:      if (enable && ch_mask != 8'd0) state_d = S_PRIME;
            S_PRIME:     state_d = S_CONVST;
            S_WAIT_TICK: if (!enable) state_d = S_IDLE;
                         else if (tick) state_d = S_CONVST;
            S_CONVST:    if (tmr_done) state_d = S_CONV;
            S_CONV:      if (tmr_done) state_d = S_SHIFT;
            S_SHIFT:     if (tmr_done && half_q == 5'd23) state_d = S_NEXT;
            S_NEXT: begin
                if (!enable || (primed_q && last_q && mask_zero_q)) state_d = S_IDLE;
                else if (!primed_q || last_q)                      state_d = S_WAIT_TICK;
                else                                               state_d = S_CONVST;
            end
            default:     state_d = S_IDLE;
        endcase
    end

    // Pin outputs decoded from the registered state.
    always_comb begin
        adc_convst = (state_q == S_CONVST);
        busy       = (state_q != S_IDLE);
        adc_sdi    = 1'b0;
        if (state_q == S_SHIFT && bit_k < 4'd6) adc_sdi = cfg_word[3'(4'd5 - bit_k)];
    end

    // Sample tick divider, held at zero while disabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       div_q <= 16'd0;
        else if (!enable) div_q <= 16'd0;
        else if (tick)    div_q <= 16'd0;
        else              div_q <= div_q + 16'd1;
    end

    // Phase timer: reloaded on each state entry and on each SCLK half period.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmr_q <= 16'd0;
        end else if (state_d != state_q) begin
            case (state_d)
                S_CONVST: tmr_q <= 16'(CONVST_HI - 1);
                S_CONV:   tmr_q <= 16'(CONV_CYCLES - 1);
                S_SHIFT:  tmr_q <= 16'(SCLK_HALF - 1);
                default:  tmr_q <= 16'd0;
            endcase
        end else if (state_q == S_SHIFT && tmr_done) begin
            tmr_q <= 16'(SCLK_HALF - 1);
        end else if (!tmr_done) begin
            tmr_q <= tmr_q - 16'd1;
        end
    end

    // SCLK generation and MSB-first capture of SDO on each rising edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_q <= 1'b0;
            half_q <= 5'd0;
            sh_q   <= 12'd0;
        end else if (state_q != S_SHIFT) begin
            sclk_q <= 1'b0;
            half_q <= 5'd0;
        end else if (tmr_done) begin
            sclk_q <= ~sclk_q;
            half_q <= half_q + 5'd1;
            if (!sclk_q) sh_q <= {sh_q[10:0], adc_sdo};
        end
    end

    // Scan bookkeeping: which channel this frame configures and which
    // channel's result is coming out. The next channel is decided at the end
    // of CONV, so a last-frame mask resample is seen before SHIFT starts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_mask_q <= 8'd0;
            cur_ch_q    <= 3'd0;
            nxt_ch_q    <= 3'd0;
            cur_first_q <= 1'b0;
            nxt_first_q <= 1'b0;
            last_q      <= 1'b0;
            mask_zero_q <= 1'b0;
            primed_q    <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: if (state_d == S_PRIME) begin
                    scan_mask_q <= ch_mask;
                    primed_q    <= 1'b0;
                end
                S_PRIME: begin
                    nxt_ch_q    <= fs[2:0];
                    nxt_first_q <= 1'b1;
                end
                S_CONV: if (tmr_done && primed_q) begin
                    if (!nb[3]) begin
                        scan_mask_q <= ch_mask;
                        nxt_ch_q    <= lm[3] ? lm[2:0] : 3'd0;
                        nxt_first_q <= 1'b1;
                        last_q      <= 1'b1;
                        mask_zero_q <= (ch_mask == 8'd0);
                    end else begin
                        nxt_ch_q    <= nb[2:0];
                        nxt_first_q <= 1'b0;
                        last_q      <= 1'b0;
                    end
                end
                S_NEXT: begin
                    cur_ch_q    <= nxt_ch_q;
                    cur_first_q <= nxt_first_q;
                    primed_q    <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Single-entry output register; a sample arriving while full is dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            smp_data  <= 12'd0;
            smp_ch    <= 3'd0;
            smp_first <= 1'b0;
            smp_valid <= 1'b0;
            ovf_count <= 16'd0;
        end else begin
            if (load_smp) begin
`ifdef ADC_TESTPAT_EN
                smp_data  <= test_mode ? {cur_ch_q, frm_q} : sh_q;
`else
                smp_data  <= sh_q;
`endif
                smp_ch    <= cur_ch_q;
                smp_first <= cur_first_q;
                smp_valid <= 1'b1;
            end else if (smp_valid && smp_ready) begin
                smp_valid <= 1'b0;
            end
            if (at_next && !load_smp && ovf_count != 16'hFFFF) ovf_count <= ovf_count + 16'd1;
        end
    end

    // Ticks that arrive mid-scan are counted, not queued.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) miss_count <= 16'd0;
        else if (tick && state_q != S_IDLE && state_q != S_WAIT_TICK && miss_count != 16'hFFFF)
            miss_count <= miss_count + 16'd1;
    end

`ifdef ADC_TESTPAT_EN
    // Frame counter for the test pattern, advancing on every delivered frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       frm_q <= 9'd0;
        else if (at_next) frm_q <= frm_q + 9'd1;
    end
`endif

endmodule
